// File: rtl/mux_nto1_seq_pkg.sv
// Shared state encodings and mode constants for the registered N-to-1 mux.
package mux_nto1_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nto1_seq_if.sv
// Output beat bundle of the registered mux: data, channel index and valid/ready.
interface mux_nto1_seq_if #(
  parameter int N = 8,
  parameter int W = 1
);
  localparam int SELW = $clog2(N);

  logic [W-1:0]    f;
  logic            f_valid;
  logic            f_ready;
  logic [SELW-1:0] ch;

  modport master (output f, output f_valid, output ch, input f_ready);
  modport slave  (input f, input f_valid, input ch, output f_ready);

endinterface

// File: rtl/mux_nto1_seq_next_ch.sv
// Finds the next enabled channel at or after ptr and flags when it is the last one.
// With MUX_NTO1_SEQ_MASK_EN undefined every channel is enabled and no mask port exists.
module mux_nto1_next_ch #(
  parameter int N = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic [SELW-1:0] ptr,
`ifdef MUX_NTO1_SEQ_MASK_EN
  input  logic [N-1:0]    mask,
`endif
  output logic [SELW-1:0] nxt,
  output logic            found,
  output logic            none_left
);

`ifdef MUX_NTO1_SEQ_MASK_EN
  always_comb begin
    nxt       = '0;
    found     = 1'b0;
    none_left = 1'b1;
    // Descending scan so the lowest qualifying index wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (mask[k] && (k >= int'(ptr))) begin
        nxt   = SELW'(k);
        found = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (mask[k] && (k > int'(nxt))) none_left = 1'b0;
    end
  end
`else
  assign nxt       = ptr;
  assign found     = 1'b1;
  assign none_left = (ptr == SELW'(N - 1));
`endif

endmodule

// File: rtl/mux_nto1_seq.sv
// Registered N-to-1, W-bit mux: direct mode follows sel, scan mode walks all channels
// under valid/ready. Define MUX_NTO1_SEQ_MASK_EN to add the en_mask channel-enable port.
module mux_nto1_seq
  import mux_nto1_seq_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 1,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*W-1:0]  a,
  input  logic [SELW-1:0] sel,
  input  logic            mode,
  input  logic            start,
`ifdef MUX_NTO1_SEQ_MASK_EN
  input  logic [N-1:0]    en_mask,
`endif
  mux_nto1_seq_if.master  mbus,
  output logic            busy,
  output logic            done
);

  localparam int AW = $clog2(N * W);

  state_e          state, state_nx;
  logic [SELW-1:0] ptr, ptr_nx;
  logic [SELW-1:0] ch_r, ch_nx;
  logic [SELW-1:0] nxt, idx;
  logic [W-1:0]    f_r, f_nx, a_sel;
  logic [AW-1:0]   base;
  logic            vld_r, vld_nx;
  logic            pending, pending_nx;
  logic            busy_nx, done_nx;
  logic            found, none_left;
  logic            load_ok, sel_ok, sel_en;

  mux_nto1_next_ch #(.N(N)) u_next (
    .ptr       (ptr),
`ifdef MUX_NTO1_SEQ_MASK_EN
    .mask      (en_mask),
`endif
    .nxt       (nxt),
    .found     (found),
    .none_left (none_left)
  );

`ifdef MUX_NTO1_SEQ_MASK_EN
  assign sel_en = en_mask[sel];
`else
  assign sel_en = 1'b1;
`endif

  // One shared slice select: direct mode reads sel, scan reads the next enabled pointer.
  assign idx     = ((state == ST_IDLE) && (mode == MODE_DIRECT)) ? sel : nxt;
  assign base    = AW'(int'(idx) * W);
  assign a_sel   = a[base +: W];
  assign sel_ok  = (int'(sel) < N) && sel_en;
  assign load_ok = !vld_r || mbus.f_ready;

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    pending_nx = pending;
    f_nx       = f_r;
    ch_nx      = ch_r;
    vld_nx     = vld_r;
    busy_nx    = busy;
    done_nx    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (mode == MODE_SCAN) begin
          if (start) begin
            state_nx   = ST_SCAN;
            busy_nx    = 1'b1;
            pending_nx = 1'b1;
            if (load_ok) begin
              if (found) begin
                f_nx       = a_sel;
                ch_nx      = nxt;
                vld_nx     = 1'b1;
                ptr_nx     = nxt + SELW'(1);
                pending_nx = !none_left;
              end else begin
                vld_nx = 1'b0;
              end
            end
          end else if (vld_r && mbus.f_ready) begin
            vld_nx = 1'b0;
          end
        end else if (load_ok) begin
          if (sel_ok) begin
            f_nx   = a_sel;
            ch_nx  = sel;
            vld_nx = 1'b1;
          end else begin
            vld_nx = 1'b0;
          end
        end
      end

      ST_SCAN: begin
        if (load_ok) begin
          if (pending && found) begin
            f_nx       = a_sel;
            ch_nx      = nxt;
            vld_nx     = 1'b1;
            ptr_nx     = nxt + SELW'(1);
            pending_nx = !none_left;
          end else begin
            // Last beat accepted (or nothing enabled remains): close the scan.
            vld_nx     = 1'b0;
            busy_nx    = 1'b0;
            done_nx    = 1'b1;
            ptr_nx     = '0;
            pending_nx = 1'b0;
            state_nx   = ST_IDLE;
          end
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      pending <= 1'b0;
      f_r     <= '0;
      ch_r    <= '0;
      vld_r   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      pending <= pending_nx;
      f_r     <= f_nx;
      ch_r    <= ch_nx;
      vld_r   <= vld_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

  assign mbus.f       = f_r;
  assign mbus.ch      = ch_r;
  assign mbus.f_valid = vld_r;

endmodule
